buzzer_alarm: RTL and testbench
===============================

// Module: buzzer_alarm
// PURPOSE
// Attempt-driven alarm sounder; parametrised successor of the single-level buzzer driver.
// Watches the failed-attempt counter from the top level and drives the buzzer pin.
// - When the counter reaches a threshold, plays a cadenced beep pattern: ON/OFF bursts, N repeats or continuous.
// - Drives either an active buzzer (steady level) or a passive one (square-wave tone).
// - Can be silenced by an acknowledge input.
// PARAMETERS
// CNT_W     2           width of attempts input
// THRESH    3           attempts value (>=) that triggers the alarm; 1..2^CNT_W-1
// CLK_HZ    50_000_000  clk frequency in Hz
// TONE_HZ   2_000       passive-buzzer tone frequency in Hz
// ON_MS     200         beep burst length in ms (>=1)
// OFF_MS    100         silence between bursts in ms (>=1)
// N_BEEPS   3           bursts per alarm; 0 = repeat until ack or attempts < THRESH
// PASSIVE   1           1: buzz toggles at TONE_HZ during bursts; 0: buzz steady 1 during bursts
// PORTS
// clk       in   1      system clock
// rst_n     in   1      asynchronous active-low reset
// attempts  in   CNT_W  failed-attempt count; top level clears it when ultrasonic sees no presence
// enable    in   1      0 = alarm inhibited (no trigger; active alarm aborts to IDLE)
// ack       in   1      1-cycle pulse, silences a running alarm
// buzz      out  1      buzzer drive, registered
// active    out  1      1 while in BEEP_ON or BEEP_OFF, registered
// done      out  1      1 while in HOLD, registered
// BEHAVIOUR
// - Derived constants:
//   ON_CYC = CLK_HZ/1000*ON_MS; OFF_CYC = CLK_HZ/1000*OFF_MS; HALF = CLK_HZ/(2*TONE_HZ), min 1.
//   Counters sized with $clog2, no wrap.
// - trig = enable & (attempts >= THRESH); unsigned compare at CNT_W bits.
// - Reset (async, rst_n=0): state=IDLE; buzz=0, active=0, done=0; all counters 0.
// - IDLE
//   - trig -> BEEP_ON, burst count=0.
//   - buzz=1 after that same edge: 1 cycle latency from attempts reaching THRESH.
// - BEEP_ON lasts exactly ON_CYC cycles, then -> BEEP_OFF.
//   - PASSIVE=1: tone phase restarts high at every BEEP_ON entry and toggles every HALF cycles.
//   - PASSIVE=0: buzz=1 for the whole burst.
// - BEEP_OFF lasts exactly OFF_CYC cycles with buzz=0, burst count+1.
//   - If N_BEEPS!=0 and count==N_BEEPS -> HOLD, else -> BEEP_ON.
// - HOLD: buzz=0, done=1. Moves to IDLE when attempts < THRESH. No retrigger while attempts stays high.
// - ack=1 in BEEP_ON/BEEP_OFF -> HOLD on that edge; buzz=0 from that edge. ack in IDLE/HOLD is ignored.
// - enable=0 in any state -> IDLE on that edge; buzz=0. Priority: enable=0 > ack > timers.
// - attempts < THRESH during BEEP_ON/BEEP_OFF: N_BEEPS=0 -> IDLE at end of current burst;
//   N_BEEPS!=0 -> pattern completes.
// - attempts value increasing during an alarm has no effect (level compare only).
// - rst_n asserted mid-burst: outputs 0 immediately, no pending state retained.
// - buzz is glitch-free: driven from a flop only.
// TESTING
// Sim params: CLK_HZ=1000, TONE_HZ=100 (HALF=5), ON_MS=20, OFF_MS=10, THRESH=3, CNT_W=2.
// 1 attempts 0->1->2, N_BEEPS=3 -> buzz stays 0, active=0.
// 2 attempts=3, PASSIVE=0, N_BEEPS=3 -> buzz high 20 cyc / low 10 cyc x3, 1 cyc after trig; then done=1, buzz=0.
// 3 PASSIVE=1 -> in each burst buzz = 5 high, 5 low, repeated, phase restarts high at each burst.
// 4 N_BEEPS=0, attempts=3, ack at cycle 45 -> buzz=0 from cycle 46, done=1; attempts->0 -> IDLE; attempts=3 again -> new alarm.
// 5 enable=0 mid-burst -> IDLE next edge, buzz=0, active=0; attempts=3 held, enable=0 -> no trigger.
// 6 rst_n low mid-burst -> buzz/active/done=0 asynchronously; release with attempts=3 -> alarm restarts at burst 0.

Source files
------------

// File: rtl/buzzer_alarm.sv
// Attempt-driven alarm sounder: once the failed-attempt count reaches THRESH it plays
// ON/OFF beep bursts (N_BEEPS times, or continuously) on an active or passive buzzer.
module buzzer_alarm #(
    parameter int CNT_W   = 2,
    parameter int THRESH  = 3,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TONE_HZ = 2_000,
    parameter int ON_MS   = 200,
    parameter int OFF_MS  = 100,
    parameter int N_BEEPS = 3,
    parameter int PASSIVE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] attempts,
    input  logic             enable,
    input  logic             ack,
    output logic             buzz,
    output logic             active,
    output logic             done
);

    localparam int ON_CYC   = CLK_HZ / 1000 * ON_MS;
    localparam int OFF_CYC  = CLK_HZ / 1000 * OFF_MS;
    localparam int HALF_RAW = CLK_HZ / (2 * TONE_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int MAX_CYC  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int HW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW       = (N_BEEPS > 0) ? $clog2(N_BEEPS + 1) : 1;

    localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESH);
    localparam logic [TW-1:0]    ON_LAST    = TW'(ON_CYC - 1);
    localparam logic [TW-1:0]    OFF_LAST   = TW'(OFF_CYC - 1);
    localparam logic [HW-1:0]    HALF_LAST  = HW'(HALF - 1);
    localparam logic [BW-1:0]    LAST_BEEP  = BW'((N_BEEPS > 0) ? N_BEEPS - 1 : 0);
    localparam logic             CONTINUOUS = (N_BEEPS == 0);
    localparam logic             TONE       = (PASSIVE != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [TW-1:0]   tcnt_r, tcnt_s;
    logic [HW-1:0]   hcnt_r, hcnt_s;
    logic [BW-1:0]   bcnt_r, bcnt_s;
    logic            buzz_r, buzz_s;
    logic            active_r, done_r;
    logic            level_s, trig_s;

    assign level_s = (attempts >= THR);
    assign trig_s  = enable & level_s;

    // Next-state, phase timers and next buzz level (outputs follow the next state).
    always_comb begin
        state_s = state_r;
        tcnt_s  = tcnt_r;
        hcnt_s  = hcnt_r;
        bcnt_s  = bcnt_r;
        buzz_s  = 1'b0;
        if (!enable) begin
            state_s = IDLE;
            tcnt_s  = '0;
            hcnt_s  = '0;
            bcnt_s  = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        state_s = BEEP_ON;
                        tcnt_s  = '0;
                        hcnt_s  = '0;
                        bcnt_s  = '0;
                        buzz_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BEEP_ON: begin
                    if (ack) begin
                        state_s = HOLD;
                        tcnt_s  = '0;
                        hcnt_s  = '0;
                    end else if (tcnt_r == ON_LAST) begin
                        tcnt_s  = '0;
                        hcnt_s  = '0;
                        // a continuous alarm stops at the burst boundary once attempts drop
                        if (CONTINUOUS && !level_s) begin
                            state_s = IDLE;
                        end else begin
                            state_s = BEEP_OFF;
                        end
                    end else begin
                        tcnt_s = tcnt_r + 1'b1;
                        if (!TONE) begin
                            buzz_s = 1'b1;
                        end else if (hcnt_r == HALF_LAST) begin
                            hcnt_s = '0;
                            buzz_s = ~buzz_r;
                        end else begin
                            hcnt_s = hcnt_r + 1'b1;
                            buzz_s = buzz_r;
                        end
                    end
                end
                BEEP_OFF: begin
                    if (ack) begin
                        state_s = HOLD;
                        tcnt_s  = '0;
                    end else if (tcnt_r == OFF_LAST) begin
                        tcnt_s = '0;
                        hcnt_s = '0;
                        if (!CONTINUOUS && bcnt_r == LAST_BEEP) begin
                            state_s = HOLD;
                        end else if (CONTINUOUS && !level_s) begin
                            state_s = IDLE;
                        end else begin
                            state_s = BEEP_ON;
                            bcnt_s  = CONTINUOUS ? bcnt_r : bcnt_r + 1'b1;
                            buzz_s  = 1'b1;
                        end
                    end else begin
                        tcnt_s = tcnt_r + 1'b1;
                    end
                end
                HOLD: begin
                    if (!level_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    tcnt_s  = '0;
                    hcnt_s  = '0;
                    bcnt_s  = '0;
                end
            endcase
        end
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            tcnt_r   <= '0;
            hcnt_r   <= '0;
            bcnt_r   <= '0;
            buzz_r   <= 1'b0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            tcnt_r   <= tcnt_s;
            hcnt_r   <= hcnt_s;
            bcnt_r   <= bcnt_s;
            buzz_r   <= buzz_s;
            active_r <= (state_s == BEEP_ON) || (state_s == BEEP_OFF);
            done_r   <= (state_s == HOLD);
        end
    end

    assign buzz   = buzz_r;
    assign active = active_r;
    assign done   = done_r;

endmodule

// File: tb/tb_buzzer_alarm.sv
// Bench for buzzer_alarm: two instances (active buzzer / 3 beeps, passive buzzer / continuous)
// checked every cycle against a timeline model of the alarm pattern.
module tb_buzzer_alarm;

    localparam int CNT_W  = 2;
    localparam int THRESH = 3;
    localparam int ON     = 20;
    localparam int OFF    = 10;
    localparam int PER    = ON + OFF;
    localparam int HALF   = 5;
    localparam int M_IDLE  = 0;
    localparam int M_ALARM = 1;
    localparam int M_HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] attempts = 2'd0;
    logic             enable = 1'b0;
    logic             ack = 1'b0;
    logic             buzz_a, active_a, done_a;
    logic             buzz_b, active_b, done_b;

    int checks = 0;
    int errors = 0;
    int mode [2];
    int pos  [2];
    int nb   [2] = '{3, 0};
    bit pas  [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    buzzer_alarm #(.CNT_W(CNT_W), .THRESH(THRESH), .CLK_HZ(1000), .TONE_HZ(100),
                   .ON_MS(20), .OFF_MS(10), .N_BEEPS(3), .PASSIVE(0)) u_active (
        .clk(clk), .rst_n(rst_n), .attempts(attempts), .enable(enable), .ack(ack),
        .buzz(buzz_a), .active(active_a), .done(done_a));

    buzzer_alarm #(.CNT_W(CNT_W), .THRESH(THRESH), .CLK_HZ(1000), .TONE_HZ(100),
                   .ON_MS(20), .OFF_MS(10), .N_BEEPS(0), .PASSIVE(1)) u_passive (
        .clk(clk), .rst_n(rst_n), .attempts(attempts), .enable(enable), .ack(ack),
        .buzz(buzz_b), .active(active_b), .done(done_b));

    // Advance the model by one clock edge; pos counts cycles since the alarm started.
    function automatic void model_edge(int k);
        bit lvl = (int'(attempts) >= THRESH);
        int np;
        if (!rst_n || !enable) begin
            mode[k] = M_IDLE;
            return;
        end
        case (mode[k])
            M_IDLE: begin
                if (lvl) begin
                    mode[k] = M_ALARM;
                    pos[k]  = 0;
                end
            end
            M_ALARM: begin
                np = pos[k] + 1;
                if (ack)
                    mode[k] = M_HOLD;
                else if (nb[k] != 0 && np == nb[k] * PER)
                    mode[k] = M_HOLD;
                else if (nb[k] == 0 && !lvl && (np % PER == ON || np % PER == 0))
                    mode[k] = M_IDLE;
                else
                    pos[k] = np;
            end
            M_HOLD: begin
                if (!lvl) mode[k] = M_IDLE;
            end
            default: mode[k] = M_IDLE;
        endcase
    endfunction

    function automatic logic exp_buzz(int k);
        int w = pos[k] % PER;
        if (mode[k] != M_ALARM || w >= ON) return 1'b0;
        if (!pas[k]) return 1'b1;
        return ((w / HALF) % 2 == 0);
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(string phase);
        chk({phase, ":buzz_a"},   buzz_a,   exp_buzz(0));
        chk({phase, ":active_a"}, active_a, mode[0] == M_ALARM);
        chk({phase, ":done_a"},   done_a,   mode[0] == M_HOLD);
        chk({phase, ":buzz_b"},   buzz_b,   exp_buzz(1));
        chk({phase, ":active_b"}, active_b, mode[1] == M_ALARM);
        chk({phase, ":done_b"},   done_b,   mode[1] == M_HOLD);
    endtask

    task automatic step(string phase, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            check_all(phase);
            ack = 1'b0;
        end
    endtask

    task automatic model_reset();
        mode[0] = M_IDLE; mode[1] = M_IDLE;
        pos[0]  = 0;      pos[1]  = 0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        step("reset_hold", 2);
        rst_n  = 1'b1;
        enable = 1'b1;

        // below threshold: nothing sounds
        for (int v = 0; v < 3; v++) begin
            attempts = 2'(v);
            step("below", 8);
        end

        // full pattern: 3 bursts then HOLD on A, continuous tone on B
        attempts = 2'd3;
        step("pattern", 100);
        attempts = 2'd0;
        step("release", 40);

        // ack mid-alarm, release, retrigger
        attempts = 2'd3;
        step("pre_ack", 45);
        ack = 1'b1;
        step("ack", 10);
        attempts = 2'd0;
        step("ack_release", 35);
        attempts = 2'd3;
        step("retrig", 20);

        // enable low aborts and inhibits
        enable = 1'b0;
        step("disable", 15);
        enable = 1'b1;
        step("reenable", 12);

        // asynchronous reset mid-burst
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        step("rst_low", 2);
        rst_n = 1'b1;
        step("rst_restart", 40);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) attempts = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 149) != 0);
            ack    = ($urandom_range(0, 59) == 0);
            step("random", 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
